tree_leaf_ni: RTL and testbench

Leaf network interface between one processing element (PE) and a child port of a tree-NoC router. On transmit, it stamps the leaf's own address onto each PE request to form a flit, then buffers it toward the router's child input. On receive, it accepts flits from the router's child output, checks the destination field, delivers matching flits to the PE and discards misrouted ones. It is synchronous, clocked RTL. The CSP channel bridge sits outside this block.

---
 rtl/tree_noc_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/tree_leaf_ni.sv | 113 +++++++++++
 tb/tb_tree_leaf_ni.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_noc_pkg.sv
// Shared definitions for the tree-NoC leaf interface: flit layout, default widths
// and the saturating error-counter helper.
package tree_noc_pkg;

  localparam int unsigned WIDTH_PACKET = 14;
  localparam int unsigned WIDTH_ADDR   = 3;
  localparam int unsigned WIDTH_DEST   = 3;
  localparam int unsigned WIDTH_FLIT   = WIDTH_PACKET + WIDTH_ADDR + WIDTH_DEST;
  localparam int unsigned ERR_CNT_W    = 8;

  // Flit as seen on the router ports: payload in the MSBs, destination in the LSBs.
  typedef struct packed {
    logic [WIDTH_PACKET-1:0] payload;
    logic [WIDTH_ADDR-1:0]   src;
    logic [WIDTH_DEST-1:0]   dest;
  } flit_t;

  // Add 0..2 events to the counter, sticking at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_sat_add(input logic [ERR_CNT_W-1:0] cnt,
                                                       input logic [1:0]           inc);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
    return sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy. Push is ignored when full and pop when
// empty; a simultaneous push and pop leaves the level unchanged.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [PtrW:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (PtrW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage and pointers; storage is cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PtrW+1)'(1);
        2'b01:   r_level <= r_level - (PtrW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tree_leaf_ni.sv
// Leaf network interface: stamps the source address on PE requests toward the router,
// filters incoming flits by destination, and counts dropped traffic.
module tree_leaf_ni
  import tree_noc_pkg::*;
#(
  parameter int unsigned          WIDTH_packet = WIDTH_PACKET,
  parameter int unsigned          WIDTH_addr   = WIDTH_ADDR,
  parameter int unsigned          WIDTH_dest   = WIDTH_DEST,
  parameter int unsigned          WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
  parameter logic [WIDTH_dest-1:0] ADDR        = '0,
  parameter int unsigned          TX_DEPTH     = 4,
  parameter int unsigned          RX_DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pe_tx_valid,
  output logic                        pe_tx_ready,
  input  logic [WIDTH_dest-1:0]       pe_tx_dest,
  input  logic [WIDTH_packet-1:0]     pe_tx_data,
  output logic                        noc_out_valid,
  input  logic                        noc_out_ready,
  output logic [WIDTH-1:0]            noc_out_flit,
  input  logic                        noc_in_valid,
  output logic                        noc_in_ready,
  input  logic [WIDTH-1:0]            noc_in_flit,
  output logic                        pe_rx_valid,
  input  logic                        pe_rx_ready,
  output logic [WIDTH_addr-1:0]       pe_rx_src,
  output logic [WIDTH_packet-1:0]     pe_rx_data,
  output logic [ERR_CNT_W-1:0]        err_cnt,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);

  localparam int unsigned RxW = WIDTH_packet + WIDTH_addr;

  logic                     w_tx_fire;
  logic                     w_self_send;
  logic                     w_tx_push;
  logic [WIDTH-1:0]         w_tx_flit;
  logic                     w_tx_full;
  logic                     w_tx_empty;
  logic                     w_rx_fire;
  logic                     w_rx_hit;
  logic                     w_misroute;
  logic [RxW-1:0]           w_rx_head;
  logic                     w_rx_full;
  logic                     w_rx_empty;
  logic [$clog2(RX_DEPTH):0] w_rx_level;
  logic                     w_unused_rx_level;
  logic [1:0]               w_err_inc;
  logic [ERR_CNT_W-1:0]     r_err_cnt;

  // TX: self-addressed requests are swallowed and counted rather than sent.
  assign w_tx_fire   = pe_tx_valid & pe_tx_ready;
  assign w_self_send = w_tx_fire & (pe_tx_dest == ADDR);
  assign w_tx_push   = w_tx_fire & ~w_self_send;
  assign w_tx_flit   = {pe_tx_data, ADDR, pe_tx_dest};

  assign pe_tx_ready   = ~w_tx_full;
  assign noc_out_valid = ~w_tx_empty;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_tx_push),
    .i_data (w_tx_flit),
    .i_pop  (noc_out_ready),
    .o_data (noc_out_flit),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty),
    .o_level(tx_level)
  );

  // RX: readiness depends only on occupancy; the destination is checked after acceptance.
  assign w_rx_fire  = noc_in_valid & noc_in_ready;
  assign w_rx_hit   = (noc_in_flit[WIDTH_dest-1:0] == ADDR);
  assign w_misroute = w_rx_fire & ~w_rx_hit;

  assign noc_in_ready = ~w_rx_full;
  assign pe_rx_valid  = ~w_rx_empty;
  assign pe_rx_data   = w_rx_head[RxW-1:WIDTH_addr];
  assign pe_rx_src    = w_rx_head[WIDTH_addr-1:0];

  sync_fifo #(
    .WIDTH(RxW),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_rx_fire & w_rx_hit),
    .i_data (noc_in_flit[WIDTH-1:WIDTH_dest]),
    .i_pop  (pe_rx_ready),
    .o_data (w_rx_head),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty),
    .o_level(w_rx_level)
  );

  assign w_unused_rx_level = ^w_rx_level;

  assign w_err_inc = {1'b0, w_self_send} + {1'b0, w_misroute};
  assign err_cnt   = r_err_cnt;

  // Saturating count of self-sends and misrouted arrivals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= '0;
    else        r_err_cnt <= err_sat_add(r_err_cnt, w_err_inc);
  end

endmodule

// File: tb/tb_tree_leaf_ni.sv
// Randomized and directed bench for tree_leaf_ni against a queue-based reference model.
module tb_tree_leaf_ni;
  import tree_noc_pkg::*;

  localparam logic [2:0] MY = 3'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pe_tx_valid = 1'b0;
  logic        pe_tx_ready;
  logic [2:0]  pe_tx_dest = '0;
  logic [13:0] pe_tx_data = '0;
  logic        noc_out_valid;
  logic        noc_out_ready = 1'b0;
  logic [19:0] noc_out_flit;
  logic        noc_in_valid = 1'b0;
  logic        noc_in_ready;
  logic [19:0] noc_in_flit = '0;
  logic        pe_rx_valid;
  logic        pe_rx_ready = 1'b0;
  logic [2:0]  pe_rx_src;
  logic [13:0] pe_rx_data;
  logic [7:0]  err_cnt;
  logic [2:0]  tx_level;

  tree_leaf_ni #(
    .ADDR(MY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pe_tx_valid  (pe_tx_valid),
    .pe_tx_ready  (pe_tx_ready),
    .pe_tx_dest   (pe_tx_dest),
    .pe_tx_data   (pe_tx_data),
    .noc_out_valid(noc_out_valid),
    .noc_out_ready(noc_out_ready),
    .noc_out_flit (noc_out_flit),
    .noc_in_valid (noc_in_valid),
    .noc_in_ready (noc_in_ready),
    .noc_in_flit  (noc_in_flit),
    .pe_rx_valid  (pe_rx_valid),
    .pe_rx_ready  (pe_rx_ready),
    .pe_rx_src    (pe_rx_src),
    .pe_rx_data   (pe_rx_data),
    .err_cnt      (err_cnt),
    .tx_level     (tx_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: what the PE has queued toward the router, what awaits the PE,
  // and how many drops have been seen (capped at 255).
  logic [19:0] txq[$];
  logic [16:0] rxq[$];
  int          err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("tx_level", 32'(tx_level), 32'(txq.size()));
    chk("pe_tx_ready", 32'(pe_tx_ready), 32'(txq.size() < 4));
    chk("noc_out_valid", 32'(noc_out_valid), 32'(txq.size() > 0));
    if (txq.size() > 0) chk("noc_out_flit", 32'(noc_out_flit), 32'(txq[0]));
    chk("noc_in_ready", 32'(noc_in_ready), 32'(rxq.size() < 2));
    chk("pe_rx_valid", 32'(pe_rx_valid), 32'(rxq.size() > 0));
    if (rxq.size() > 0) begin
      chk("pe_rx_src", 32'(pe_rx_src), 32'(rxq[0][2:0]));
      chk("pe_rx_data", 32'(pe_rx_data), 32'(rxq[0][16:3]));
    end
    chk("err_cnt", 32'(err_cnt), 32'(err_m));
  endtask

  function automatic logic [19:0] mk_flit(input logic [13:0] p, input logic [2:0] s,
                                          input logic [2:0] d);
    flit_t f;
    f.payload = p;
    f.src     = s;
    f.dest    = d;
    return f;
  endfunction

  // One clock cycle: check current outputs, apply inputs, advance the model, clock.
  task automatic step(input logic tv, input logic [2:0] td, input logic [13:0] tdat,
                      input logic ordy, input logic iv, input logic [19:0] ifl,
                      input logic rrdy);
    int          ntx;
    int          nrx;
    flit_t       f;
    logic [19:0] tmp_t;
    logic [16:0] tmp_r;
    check_model();
    pe_tx_valid   = tv;
    pe_tx_dest    = td;
    pe_tx_data    = tdat;
    noc_out_ready = ordy;
    noc_in_valid  = iv;
    noc_in_flit   = ifl;
    pe_rx_ready   = rrdy;
    ntx = txq.size();
    nrx = rxq.size();
    if (ordy && ntx > 0) tmp_t = txq.pop_front();
    if (tv && ntx < 4) begin
      if (td == MY) err_m = (err_m >= 255) ? 255 : err_m + 1;
      else          txq.push_back(mk_flit(tdat, MY, td));
    end
    if (rrdy && nrx > 0) tmp_r = rxq.pop_front();
    if (iv && nrx < 2) begin
      f = ifl;
      if (f.dest == MY) rxq.push_back({f.payload, f.src});
      else              err_m = (err_m >= 255) ? 255 : err_m + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pe_tx_valid   = 1'b0;
    noc_out_ready = 1'b0;
    noc_in_valid  = 1'b0;
    pe_rx_ready   = 1'b0;
    rst_n         = 1'b0;
    txq.delete();
    rxq.delete();
    err_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_tx_level"}, 32'(tx_level), 32'd0);
    chk({pfx, "_pe_tx_ready"}, 32'(pe_tx_ready), 32'd1);
    chk({pfx, "_noc_in_ready"}, 32'(noc_in_ready), 32'd1);
    chk({pfx, "_noc_out_valid"}, 32'(noc_out_valid), 32'd0);
    chk({pfx, "_pe_rx_valid"}, 32'(pe_rx_valid), 32'd0);
    chk({pfx, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({pfx, "_noc_out_flit"}, 32'(noc_out_flit), 32'd0);
    chk({pfx, "_pe_rx_src"}, 32'(pe_rx_src), 32'd0);
    chk({pfx, "_pe_rx_data"}, 32'(pe_rx_data), 32'd0);
  endtask

  initial begin
    logic        tv, iv, ordy, rrdy, tx_hold, rx_hold;
    logic [2:0]  td;
    logic [13:0] tdat;
    logic [19:0] ifl;

    do_reset();
    check_reset_values("reset");

    // Basic send: flit carries payload, own address, destination.
    step(1'b1, 3'd5, 14'h1ABC, 1'b1, 1'b0, 20'h0, 1'b0);
    chk("t1_flit", 32'(noc_out_flit), 32'h6AF1D);
    step(1'b0, 3'd0, 14'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    chk("t1_level", 32'(tx_level), 32'd0);

    // Backpressure: five requests against a stalled router, only four fit.
    for (int i = 0; i < 5; i++)
      step(1'b1, (i < 3) ? 3'(i) : 3'(i + 1), 14'(16'h100 + i), 1'b0, 1'b0, 20'h0, 1'b0);
    chk("t2_level", 32'(tx_level), 32'd4);
    chk("t2_ready", 32'(pe_tx_ready), 32'd0);
    chk("t2_head", 32'(noc_out_flit[19:6]), 32'h100);
    step(1'b1, 3'd5, 14'h104, 1'b1, 1'b0, 20'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 14'h0, 1'b1, 1'b0, 20'h0, 1'b0);
    chk("t2_drained", 32'(tx_level), 32'd0);

    // Receive filter: only the flit addressed here is delivered.
    do_reset();
    step(1'b0, 3'd0, 14'h0, 1'b0, 1'b1, mk_flit(14'h2345, 3'd5, 3'd3), 1'b0);
    step(1'b0, 3'd0, 14'h0, 1'b0, 1'b1, mk_flit(14'h0777, 3'd1, 3'd6), 1'b0);
    chk("t3_src", 32'(pe_rx_src), 32'd5);
    chk("t3_data", 32'(pe_rx_data), 32'h2345);
    chk("t3_err", 32'(err_cnt), 32'd1);
    step(1'b0, 3'd0, 14'h0, 1'b0, 1'b0, 20'h0, 1'b1);
    chk("t3_rx_empty", 32'(pe_rx_valid), 32'd0);

    // Self-send and saturation, including cycles with two drops at once.
    step(1'b1, MY, 14'h0055, 1'b1, 1'b0, 20'h0, 1'b0);
    chk("t4_no_out", 32'(noc_out_valid), 32'd0);
    chk("t4_err", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 149; i++)
      step(1'b1, MY, 14'(i), 1'b1, 1'b1, mk_flit(14'(i), 3'd2, 3'd7), 1'b1);
    chk("t4_err_300", 32'(err_cnt), 32'd255);
    step(1'b1, MY, 14'h1, 1'b1, 1'b1, mk_flit(14'h1, 3'd2, 3'd0), 1'b1);
    chk("t4_err_sat", 32'(err_cnt), 32'd255);

    // RX backpressure, then an asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd1, 14'h3F00, 1'b0, 1'b1, mk_flit(14'h0AA0, 3'd4, MY), 1'b0);
    chk("t5_in_ready", 32'(noc_in_ready), 32'd0);
    chk("t5_rx_valid", 32'(pe_rx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    txq.delete();
    rxq.delete();
    err_m = 0;
    pe_tx_valid  = 1'b0;
    noc_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic with valid held until accepted.
    tx_hold = 1'b0;
    rx_hold = 1'b0;
    tv = 1'b0; td = '0; tdat = '0; iv = 1'b0; ifl = '0;
    for (int c = 0; c < 800; c++) begin
      if (!tx_hold) begin
        tv   = 1'($urandom_range(0, 1));
        td   = 3'($urandom_range(0, 7));
        tdat = 14'($urandom);
      end
      if (!rx_hold) begin
        iv  = 1'($urandom_range(0, 1));
        ifl = mk_flit(14'($urandom), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : MY);
      end
      ordy = 1'($urandom_range(0, 2) != 0);
      rrdy = 1'($urandom_range(0, 2) != 0);
      tx_hold = tv && (txq.size() >= 4);
      rx_hold = iv && (rxq.size() >= 2);
      step(tv, td, tdat, ordy, iv, ifl, rrdy);
    end
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
